// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths used by the master bridge and the
// register slaves, plus the bridge state encoding.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StRdWait
    } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Bounded wait on pready: counts ACCESS cycles and flags the cycle in which
// the count would reach TIMEOUT. TIMEOUT = 0 never expires.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] count_q;

    // Saturating counter, cleared when a new transfer enters SETUP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Expiry is seen in the cycle whose closing edge brings the count to TIMEOUT.
    always_comb begin
        expired = (TIMEOUT != 0) && enable && (count_q == LAST);
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to APB master bridge: one outstanding transfer,
// one response pulse per accepted command, optional wait-state timeout.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    apb_state_e        state_q, state_d;
    logic              rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              rsp_valid_d;
    logic              load;
    logic              timer_en;
    logic              timer_expired;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (load),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    // APB strobes decode straight from state so reset drops them at once.
    always_comb begin
        psel      = (state_q == StSetup) || (state_q == StAccess);
        penable   = (state_q == StAccess);
        cmd_ready = (state_q == StIdle) && !reset;
    end

    // Next-state logic and response formation.
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err;
        rsp_rdata_d = rsp_rdata;
        load        = 1'b0;
        timer_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    load    = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                timer_en = 1'b1;
                if (pready) begin
                    if (pwrite || (RD_LAT == 0)) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = pwrite ? '0 : prdata;
                        state_d     = StIdle;
                    end else begin
                        state_d = StRdWait;
                    end
                end else if (timer_expired) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = StIdle;
                end
            end
            StRdWait: begin
                // Registered-prdata slave presents its data during this cycle.
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = prdata;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, latched command fields and registered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state_q   <= state_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            if (load) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed plus randomized bench for apb_master_bridge against a registered-
// prdata APB slave and a flat memory reference model.
module tb_apb_master_bridge;

    localparam int unsigned TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready = 1'b1;
    logic       init_mem = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int n_accepts = 0;
    int exp_accepts = 0;

    logic [7:0] slv_mem [256];
    logic [7:0] ref_mem [256];

    apb_master_bridge #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .TIMEOUT (TIMEOUT),
        .RD_LAT  (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] preload(input int a);
        logic [7:0] v;
        v = 8'(a) ^ 8'h3C;
        if (a == 'hA5) v = 8'h5A;
        return v;
    endfunction

    // Registered-prdata APB slave.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) slv_mem[i] <= preload(i);
        end else if (psel && penable && pready) begin
            if (pwrite) slv_mem[paddr] <= pwdata;
            else        prdata <= slv_mem[paddr];
        end
    end

    // Handshake monitor: every accept counted once.
    always @(posedge clk) begin
        if (!reset && cmd_valid && cmd_ready) n_accepts++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Issue one command starting at a negedge with the bridge idle; returns at
    // the negedge of the response cycle.
    task automatic run_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                           input int waits, input bit stuck, input bit keep_valid,
                           input logic nwr, input logic [7:0] naddr, input logic [7:0] nwd);
        int n_access;
        int cyc;
        bit done;
        int exp_access;
        logic [7:0] exp_rd;
        exp_access = stuck ? TIMEOUT : waits + 1;
        exp_rd = (wr || stuck) ? 8'h00 : ref_mem[addr];
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        pready    = 1'b0;
        check("cmd_ready_idle", cmd_ready, 1);
        exp_accepts++;
        @(negedge clk);
        cyc = 1;
        if (keep_valid) begin
            cmd_write = nwr;
            cmd_addr  = naddr;
            cmd_wdata = nwd;
        end else begin
            cmd_valid = 1'b0;
        end
        check("setup_psel", psel, 1);
        check("setup_penable", penable, 0);
        check("setup_paddr", paddr, addr);
        check("setup_pwrite", pwrite, wr);
        check("setup_cmd_ready", cmd_ready, 0);
        check("setup_rsp_valid", rsp_valid, 0);
        n_access = 0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            cyc++;
            if (psel && penable) begin
                n_access++;
                pready = !stuck && (n_access > waits);
                check("access_paddr", paddr, addr);
                if (wr) check("access_pwdata", pwdata, wd);
                check("access_cmd_ready", cmd_ready, 0);
            end else begin
                done = 1;
            end
        end
        pready = 1'b1;
        check("access_cycles", n_access, exp_access);
        if (!wr && !stuck) begin
            check("rdwait_psel", psel, 0);
            check("rdwait_rsp_valid", rsp_valid, 0);
            @(negedge clk);
            cyc++;
        end
        check("rsp_valid", rsp_valid, 1);
        check("rsp_err", rsp_err, stuck);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_psel", psel, 0);
        check("rsp_cmd_ready", cmd_ready, 1);
        check("rsp_latency", cyc, 1 + exp_access + 1 + ((!wr && !stuck) ? 1 : 0));
        if (wr && !stuck) ref_mem[addr] = wd;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = preload(i);
        @(negedge clk);
        // Reset state
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        @(negedge clk);
        init_mem = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Basic write, then registered-slave read
        run_cmd(1, 8'h10, 8'h3C, 0, 0, 0, 0, 0, 0);
        run_cmd(0, 8'hA5, 8'h00, 0, 0, 0, 0, 0, 0);
        // Wait states then readback of the earlier write
        run_cmd(0, 8'h10, 8'h00, 3, 0, 0, 0, 0, 0);
        run_cmd(1, 8'h44, 8'hE1, 3, 0, 0, 0, 0, 0);
        // Timeout, then a normal command
        run_cmd(1, 8'h55, 8'h99, 0, 1, 0, 0, 0, 0);
        run_cmd(0, 8'h55, 8'h00, 0, 0, 0, 0, 0, 0);
        run_cmd(0, 8'h66, 8'h00, 0, 1, 0, 0, 0, 0);
        // Back-to-back with cmd_valid held across the first transfer
        run_cmd(1, 8'h20, 8'h77, 1, 0, 1, 0, 8'h20, 8'h00);
        run_cmd(0, 8'h20, 8'h00, 0, 0, 0, 0, 0, 0);

        // Reset during ACCESS
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h30;
        cmd_wdata = 8'hAB;
        pready    = 1'b0;
        exp_accepts++;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_penable", penable, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_psel", psel, 0);
        check("async_rst_penable", penable, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        pready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_rsp_valid", rsp_valid, 0);
            check("post_rst_cmd_ready", cmd_ready, 1);
            check("post_rst_psel", psel, 0);
        end
        run_cmd(0, 8'h30, 8'h00, 0, 0, 0, 0, 0, 0);

        // Randomized traffic against the memory model
        for (int i = 0; i < 24; i++) begin
            logic       rwr;
            logic [7:0] raddr;
            logic [7:0] rwd;
            int         rwaits;
            bit         rstuck;
            rwr    = 1'($urandom_range(0, 1));
            raddr  = 8'($urandom_range(0, 15)) | 8'h80;
            rwd    = 8'($urandom);
            rwaits = $urandom_range(0, 3);
            rstuck = ($urandom_range(0, 7) == 0);
            run_cmd(rwr, raddr, rwd, rwaits, rstuck, 0, 0, 0, 0);
        end

        @(negedge clk);
        check("accept_count", n_accepts, exp_accepts);
        check("rsp_single_pulse", rsp_valid, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts a simple valid/ready command stream from the local controller into APB SETUP/ACCESS transfers.
- Drives the APB register slaves directly upstream of them and returns one response per command: read data or error.
- Holds at most one outstanding transfer, with a bounded wait on pready.

Parameters:
ADDR_W, 8, APB address width
DATA_W, 8, APB data width
TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables timeout
RD_LAT, 1, cycles after the completion edge at which prdata is sampled (0 = same edge, 1 = one cycle later, for registered-prdata slaves)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  single-cycle response pulse; no backpressure
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  transfer timed out
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Reset asserted mid-transfer drops psel and penable immediately. No response is issued for the aborted command.
- FSM states: IDLE, SETUP, ACCESS, RDWAIT.
- cmd_ready = 1 only in IDLE.
- IDLE: on cmd_valid, register cmd_write, cmd_addr and cmd_wdata into pwrite, paddr and pwdata, then go to SETUP.
- SETUP (one cycle): psel=1, penable=0. Next state is ACCESS.
- ACCESS: psel=1, penable=1, and the wait counter increments each cycle.
  - If pready=1 and (write, or RD_LAT=0): leave ACCESS. On that edge capture prdata for reads. Pulse rsp_valid next cycle with rsp_err=0. Go to IDLE.
  - If pready=1, read, and RD_LAT=1: go to RDWAIT. psel and penable drop.
  - If pready=0 and the counter reaches TIMEOUT: psel and penable drop. Pulse rsp_valid with rsp_err=1 and rsp_rdata=0. Go to IDLE.
- RDWAIT (one cycle): capture prdata at the end of the cycle. Pulse rsp_valid next cycle. Go to IDLE.
- rsp_valid is high for exactly one cycle. rsp_rdata and rsp_err are valid only while rsp_valid=1; they hold their last value otherwise.
- paddr, pwrite and pwdata stay stable from SETUP until the transfer ends. They hold their last value in IDLE.
- Latency with pready tied high:
  - write: accept at edge 0, rsp_valid during cycle 3.
  - read with RD_LAT=1: rsp_valid during cycle 4.
- The earliest next accept is the cycle in which rsp_valid is high; IDLE and the response cycle coincide.
- A new cmd_valid arriving during a transfer is ignored (not accepted) and must be held by the source.
- With TIMEOUT=0, the block waits on pready indefinitely.
- The wait counter is $clog2(TIMEOUT+1) bits wide, saturates, and clears on entry to SETUP.

Decomposition:
- Package apb_pkg: state enum (IDLE, SETUP, ACCESS, RDWAIT); default ADDR_W/DATA_W localparams shared with the APB slave blocks.
- One natural sub-module: apb_wait_timer, holding the wait counter plus the timeout compare, with clear/enable/expired ports.

Test Plan:
1. Write, pready tied 1: cmd addr=0x10, wdata=0x3C -> SETUP cycle then ACCESS cycle with paddr=0x10 and pwdata=0x3C. Next cycle rsp_valid=1, rsp_err=0, rsp_rdata=0x00.
2. Read, RD_LAT=1, against a registered-prdata slave model preloaded with 0xA5->0x5A: cmd read addr=0xA5 -> rsp_valid at cycle 4 with rsp_rdata=0x5A.
3. Wait states: pready held low 3 ACCESS cycles, then high -> penable stays high for 4 cycles and paddr stays stable. Single response with rsp_err=0.
4. Timeout: TIMEOUT=16, pready stuck low -> after 16 ACCESS cycles psel=0 and rsp_valid=1 with rsp_err=1 and rsp_rdata=0. The next command is accepted normally.
5. Back-to-back: cmd_valid held high for a write then a read -> cmd_ready low during the first transfer. The second command is accepted in the first's response cycle and no command is dropped or duplicated.
6. Reset asserted during ACCESS -> psel and penable go to 0 asynchronously. No rsp_valid is issued, and the block returns to IDLE with cmd_ready=1 after reset release.
